findstr_prog: RTL and testbench

Programmable byte-stream pattern counter. It is the next generation of the team's fixed-string detector: the pattern, its length, the case mode and the gap policy are all set at run time. Overlapping occurrences are detected, and the block issues a per-match pulse plus a saturating occurrence count. It sits after the UART/byte receiver, on the same dv/data byte stream.

---
 rtl/findstr_pkg.sv | 26 ++
 rtl/findstr_prog_if.sv | 33 +++
 rtl/findstr_hist.sv | 30 +++
 rtl/findstr_prog.sv | 85 ++++++++
 tb/tb_findstr_prog.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/findstr_pkg.sv
// Shared constants and helpers for the programmable pattern counter.
// Holds the ASCII folding rule and the parameter-derived width helpers.
package findstr_pkg;

   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned DEF_MAX_LEN = 16;

   localparam logic [BYTE_W-1:0] CH_UPPER_A = 8'h41;
   localparam logic [BYTE_W-1:0] CH_UPPER_Z = 8'h5A;
   localparam logic [BYTE_W-1:0] CASE_OFS   = 8'h20;

   function automatic int unsigned addr_w(input int unsigned max_len);
      return $clog2(max_len);
   endfunction

   function automatic int unsigned len_w(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

   // Only A-Z move; every other code, including '[' and '{', compares raw.
   function automatic logic [BYTE_W-1:0] fold_case(input logic [BYTE_W-1:0] b, input logic en);
      if (en && (b >= CH_UPPER_A) && (b <= CH_UPPER_Z)) return b + CASE_OFS;
      return b;
   endfunction

endpackage

// File: rtl/findstr_prog_if.sv
// Byte stream, configuration and result signals of findstr_prog.
// The master side feeds bytes/config; the slave side is the counter.
interface findstr_prog_if import findstr_pkg::*; #(
   parameter int unsigned MAX_LEN = DEF_MAX_LEN,
   parameter int unsigned CNT_W   = 8
);
   localparam int unsigned ADDR_W = addr_w(MAX_LEN);
   localparam int unsigned LEN_W  = len_w(MAX_LEN);

   logic              dv;
   logic [BYTE_W-1:0] data;
   logic              cfg_we;
   logic [ADDR_W-1:0] cfg_addr;
   logic [BYTE_W-1:0] cfg_data;
   logic              cfg_len_we;
   logic [LEN_W-1:0]  cfg_len;
   logic              case_ins;
   logic              clr;
   logic              get_flag;
   logic [CNT_W-1:0]  num;
   logic              num_sat;

   modport master (
      output dv, data, cfg_we, cfg_addr, cfg_data, cfg_len_we, cfg_len, case_ins, clr,
      input  get_flag, num, num_sat
   );

   modport slave (
      input  dv, data, cfg_we, cfg_addr, cfg_data, cfg_len_we, cfg_len, case_ins, clr,
      output get_flag, num, num_sat
   );

endinterface

// File: rtl/findstr_hist.sv
// History shift register of the last MAX_LEN accepted bytes (hist[0] newest)
// with a saturating count of valid entries.
module findstr_hist import findstr_pkg::*; #(
   parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
   localparam int unsigned LEN_W   = len_w(MAX_LEN)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      shift,
   input  logic                      flush,
   input  logic [BYTE_W-1:0]         d,
   output logic [MAX_LEN*BYTE_W-1:0] hist,
   output logic [LEN_W-1:0]          hist_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist     <= '0;
         hist_cnt <= '0;
      end else begin
         if (shift) hist <= {hist[(MAX_LEN-1)*BYTE_W-1:0], d};
         // A flush together with a shift leaves the new byte as the only valid entry.
         if (flush)
            hist_cnt <= shift ? LEN_W'(1) : '0;
         else if (shift && (hist_cnt != LEN_W'(MAX_LEN)))
            hist_cnt <= hist_cnt + LEN_W'(1);
      end
   end

endmodule

// File: rtl/findstr_prog.sv
// Programmable byte-stream pattern counter: overlapping window matches,
// registered one-cycle match pulse and a saturating occurrence count.
module findstr_prog import findstr_pkg::*; #(
   parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
   parameter int unsigned CNT_W     = 8,
   parameter bit          ALLOW_GAP = 1'b1
) (
   input logic           clk,
   input logic           rst_n,
   findstr_prog_if.slave bus
);

   localparam int unsigned ADDR_W = addr_w(MAX_LEN);
   localparam int unsigned LEN_W  = len_w(MAX_LEN);

   logic [BYTE_W-1:0]         pat [2**ADDR_W];
   logic [LEN_W-1:0]          len;
   logic [MAX_LEN*BYTE_W-1:0] hist;
   logic [LEN_W-1:0]          hist_cnt;
   logic [BYTE_W-1:0]         win [MAX_LEN];
   logic                      cfg_wr;
   logic                      shift;
   logic                      flush;
   logic                      hit;
   logic                      get_flag_q;
   logic                      num_sat_q;
   logic [CNT_W-1:0]          num_q;

   assign cfg_wr = bus.cfg_we | bus.cfg_len_we;
   assign shift  = bus.dv & ~bus.clr;
   assign flush  = bus.clr | cfg_wr | (ALLOW_GAP ? 1'b0 : ~bus.dv);

   findstr_hist #(.MAX_LEN(MAX_LEN)) hist_u (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift    (shift),
      .flush    (flush),
      .d        (bus.data),
      .hist     (hist),
      .hist_cnt (hist_cnt)
   );

   // win[k] is the byte k positions back from the incoming one (win[0] = incoming).
   always_comb begin
      win[0] = bus.data;
      for (int unsigned k = 1; k < MAX_LEN; k++) win[k] = hist[(k-1)*BYTE_W +: BYTE_W];
   end

   always_comb begin
      hit = bus.dv && (len != '0) && !cfg_wr && (hist_cnt >= len - LEN_W'(1));
      for (int unsigned k = 0; k < MAX_LEN; k++) begin
         if ((k < 32'(len)) &&
             (fold_case(pat[ADDR_W'(32'(len) - 32'd1 - k)], bus.case_ins) !=
              fold_case(win[k], bus.case_ins)))
            hit = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2**ADDR_W; i++) pat[i] <= '0;
         len        <= '0;
         get_flag_q <= 1'b0;
         num_q      <= '0;
         num_sat_q  <= 1'b0;
      end else begin
         if (bus.cfg_we) pat[bus.cfg_addr] <= bus.cfg_data;
         if (bus.cfg_len_we) len <= (32'(bus.cfg_len) > MAX_LEN) ? '0 : bus.cfg_len;
         get_flag_q <= hit;
         // clr beats a same-cycle match: the pulse still fires but is not counted.
         if (bus.clr) begin
            num_q     <= '0;
            num_sat_q <= 1'b0;
         end else if (hit) begin
            if (num_q == '1) num_sat_q <= 1'b1;
            else             num_q     <= num_q + CNT_W'(1);
         end
      end
   end

   assign bus.get_flag = get_flag_q;
   assign bus.num      = num_q;
   assign bus.num_sat  = num_sat_q;

endmodule

// File: tb/tb_findstr_prog.sv
// Scoreboard bench for findstr_prog: three instances (default, strict-gap,
// 2-bit counter) share one stimulus stream; a monitor checks every pulse.
module tb_findstr_prog;
   import findstr_pkg::*;

   typedef struct {
      int cyc;
      int num;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dv = 1'b0;
   logic [7:0] data = '0;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic       cfg_len_we = 1'b0;
   logic [4:0] cfg_len = '0;
   logic       case_ins = 1'b0;
   logic       clr = 1'b0;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   exp_num [3];
   exp_t sbq [3][$];

   findstr_prog_if #(.MAX_LEN(16), .CNT_W(8)) bus_a ();
   findstr_prog_if #(.MAX_LEN(16), .CNT_W(8)) bus_g ();
   findstr_prog_if #(.MAX_LEN(16), .CNT_W(2)) bus_s ();

   assign bus_a.dv = dv, bus_a.data = data, bus_a.cfg_we = cfg_we, bus_a.cfg_addr = cfg_addr;
   assign bus_a.cfg_data = cfg_data, bus_a.cfg_len_we = cfg_len_we, bus_a.cfg_len = cfg_len;
   assign bus_a.case_ins = case_ins, bus_a.clr = clr;
   assign bus_g.dv = dv, bus_g.data = data, bus_g.cfg_we = cfg_we, bus_g.cfg_addr = cfg_addr;
   assign bus_g.cfg_data = cfg_data, bus_g.cfg_len_we = cfg_len_we, bus_g.cfg_len = cfg_len;
   assign bus_g.case_ins = case_ins, bus_g.clr = clr;
   assign bus_s.dv = dv, bus_s.data = data, bus_s.cfg_we = cfg_we, bus_s.cfg_addr = cfg_addr;
   assign bus_s.cfg_data = cfg_data, bus_s.cfg_len_we = cfg_len_we, bus_s.cfg_len = cfg_len;
   assign bus_s.case_ins = case_ins, bus_s.clr = clr;

   findstr_prog #(.MAX_LEN(16), .CNT_W(8), .ALLOW_GAP(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   findstr_prog #(.MAX_LEN(16), .CNT_W(8), .ALLOW_GAP(1'b0)) dut_g (.clk(clk), .rst_n(rst_n), .bus(bus_g));
   findstr_prog #(.MAX_LEN(16), .CNT_W(2), .ALLOW_GAP(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Monitor: every pulse must match the oldest expectation in cycle and count.
   always @(negedge clk) begin
      exp_t e;
      logic g;
      int   n;
      for (int i = 0; i < 3; i++) begin
         g = (i == 0) ? bus_a.get_flag : (i == 1) ? bus_g.get_flag : bus_s.get_flag;
         n = (i == 0) ? int'(bus_a.num) : (i == 1) ? int'(bus_g.num) : int'(bus_s.num);
         while (sbq[i].size() > 0 && sbq[i][0].cyc < cyc) begin
            e = sbq[i].pop_front();
            checks++;
            failures++;
            $display("FAIL missed_pulse dut=%0d got=no_pulse required=pulse@%0d num=%0d", i, e.cyc, e.num);
         end
         if (g) begin
            checks++;
            if (sbq[i].size() == 0) begin
               failures++;
               $display("FAIL unexpected_pulse dut=%0d cyc=%0d got=pulse num=%0d required=no_pulse", i, cyc, n);
            end else begin
               e = sbq[i].pop_front();
               if (e.cyc != cyc || e.num != n) begin
                  failures++;
                  $display("FAIL pulse dut=%0d got cyc=%0d num=%0d required cyc=%0d num=%0d", i, cyc, n, e.cyc, e.num);
               end
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   task automatic defaults();
      dv = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0; clr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(negedge clk); defaults(); end
   endtask

   // mk: '.' no match, '*' match on every instance, 'n' match except strict-gap.
   task automatic expect_mark(input byte mk, input bit in_clr);
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (mk == "*" || (mk == "n" && i != 1)) begin
            if (in_clr) exp_num[i] = 0;
            else if (exp_num[i] < ((i == 2) ? 3 : 255)) exp_num[i]++;
            e.cyc = cyc + 1;
            e.num = exp_num[i];
            sbq[i].push_back(e);
         end
      end
   endtask

   task automatic send(input byte ch, input byte mk);
      @(negedge clk); defaults();
      dv = 1'b1; data = ch;
      expect_mark(mk, 1'b0);
   endtask

   task automatic send_str(input string s, input string m);
      for (int i = 0; i < s.len(); i++) send(s[i], m[i]);
   endtask

   task automatic set_len(input int n);
      @(negedge clk); defaults();
      cfg_len_we = 1'b1; cfg_len = 5'(n);
   endtask

   task automatic set_len_dv(input int n, input byte ch);
      @(negedge clk); defaults();
      cfg_len_we = 1'b1; cfg_len = 5'(n); dv = 1'b1; data = ch;
   endtask

   task automatic prog(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk); defaults();
         cfg_we = 1'b1; cfg_addr = 4'(i); cfg_data = s[i];
      end
      set_len(s.len());
   endtask

   task automatic do_clr(input bit with_dv, input byte ch, input byte mk);
      @(negedge clk); defaults();
      clr = 1'b1; dv = with_dv; data = ch;
      expect_mark(mk, 1'b1);
      for (int i = 0; i < 3; i++) exp_num[i] = 0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) exp_num[i] = 0;
      repeat (3) @(negedge clk);
      check("rst_get_flag", bus_a.get_flag, 0);
      check("rst_num", bus_a.num, 0);
      check("rst_num_sat", bus_s.num_sat, 0);
      rst_n = 1'b1;

      // Basic detection with repeat-prefix distractor
      prog("Welcom"); do_clr(1'b0, 8'h00, ".");
      send_str("xxWelcomWWelcom", ".......*......*");
      idle(2);
      check("t1_num", bus_a.num, 2);

      // Overlapping occurrences
      prog("aa"); do_clr(1'b0, 8'h00, ".");
      send_str("aaaa", ".***");
      idle(2);
      check("t2_num_aa", bus_a.num, 3);
      check("t2_num_aa_sat", bus_s.num_sat, 0);
      prog("abab"); do_clr(1'b0, 8'h00, ".");
      send_str("ababab", "...*.*");
      idle(2);
      check("t2_num_abab", bus_a.num, 2);

      // Gap policy
      prog("abc"); do_clr(1'b0, 8'h00, ".");
      send("a", "."); idle(3); send("b", "."); send("c", "n");
      send_str("abc", "..*");
      idle(2);
      check("t3_num_gap_ok", bus_a.num, 2);
      check("t3_num_gap_strict", bus_g.num, 1);

      // Case folding, including a live mode switch and non-letter neighbours
      prog("Welcom"); case_ins = 1'b1; do_clr(1'b0, 8'h00, ".");
      send_str("wELCOM", ".....*");
      idle(1); case_ins = 1'b0;
      send_str("wELCOM", "......");
      send_str("wELCO", ".....");
      @(posedge clk); #1 case_ins = 1'b1;
      send("M", "*");
      idle(2);
      check("t4_num_fold", bus_a.num, 2);
      prog("x["); do_clr(1'b0, 8'h00, ".");
      send_str("x{x[", "...*");
      idle(1); case_ins = 1'b0;
      send_str("x{x[", "...*");
      idle(2);
      check("t4_num_brackets", bus_a.num, 2);

      // Saturation and clr precedence
      prog("a"); do_clr(1'b0, 8'h00, ".");
      send_str("aaaaa", "*****");
      idle(2);
      check("t5_num_s", bus_s.num, 3);
      check("t5_sat_s", bus_s.num_sat, 1);
      check("t5_num_a", bus_a.num, 5);
      check("t5_sat_a", bus_a.num_sat, 0);
      do_clr(1'b1, "a", "*");
      idle(2);
      check("t5_clr_num_s", bus_s.num, 0);
      check("t5_clr_sat_s", bus_s.num_sat, 0);
      check("t5_clr_num_a", bus_a.num, 0);
      prog("ab"); do_clr(1'b1, "a", ".");
      send("b", ".");
      idle(2);
      check("t5_clr_discard", bus_a.num, 0);

      // Configuration writes flush history; out-of-range and zero lengths disable
      prog("abc"); do_clr(1'b0, 8'h00, ".");
      send_str("ab", ".."); set_len(3); send("c", ".");
      set_len(20); send_str("abc", "...");
      set_len(0); send_str("abc", "...");
      set_len_dv(2, "a"); send("b", "*");
      idle(2);
      check("t6_num", bus_a.num, 1);

      // Full-length pattern
      prog("0123456789ABCDEF"); do_clr(1'b0, 8'h00, ".");
      send_str("x0123456789ABCDEF", "................*");
      idle(2);
      check("t7_num_maxlen", bus_a.num, 1);

      // Asynchronous reset mid-stream clears counters and the pattern
      @(posedge clk); #2 rst_n = 1'b0; #1;
      check("async_rst_num_a", bus_a.num, 0);
      check("async_rst_num_s", bus_s.num, 0);
      for (int i = 0; i < 3; i++) exp_num[i] = 0;
      @(negedge clk); rst_n = 1'b1;
      send_str("x0123456789ABCDEF", ".................");
      idle(4);
      for (int i = 0; i < 3; i++) check($sformatf("pending_pulses_dut%0d", i), sbq[i].size(), 0);
      check("final_num_a", bus_a.num, exp_num[0]);
      check("final_num_g", bus_g.num, exp_num[1]);
      check("final_num_s", bus_s.num, exp_num[2]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
